ldm_stm_seq: RTL and testbench

Block-transfer sequencer for the 32-bit core that drives the register file's read ports (store-multiple) and write port (load-multiple). It walks a 16-bit register list in ascending order and issues one memory word access per listed register over a valid/ready memory handshake. It optionally writes back the updated base. It sits between the decode/execute stage and the register file and data-memory interface. R15 is never written through the register file; a load to R15 goes out on a dedicated PC write port.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/reg_list_prienc.sv | 38 +++
 rtl/ldm_stm_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 32-bit core's block-transfer
//               sequencer: sequencer state encoding, word size, PC register
//               index and register-index/list widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int WORD_BYTES = 4;   // bytes per memory word access
  localparam int PC_IDX     = 15;  // register index that aliases the PC
  localparam int REG_IDX_W  = 5;   // register file index width
  localparam int LIST_W     = 16;  // register list width
  localparam int IDX_W      = 4;   // index of a bit within the list
  localparam int CNT_W      = 5;   // popcount of a full list (0..16)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_list_prienc.sv
`default_nettype none
// ============================================================================
// Module      : reg_list_prienc
// Description : Combinational register-list decoder. Reports the lowest set
//               bit of a 16-bit list, whether any bit is set, and the number
//               of set bits.
// Ports       : list_i  - register list
//               idx_o   - index of the lowest set bit (0 when list is empty)
//               valid_o - list is non-empty
//               count_o - popcount of the list
// Revision    : 1.0 - initial release
// ============================================================================
module reg_list_prienc
  import cpu_pkg::*;
(
  input  logic [LIST_W-1:0] list_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  always_comb begin
    idx_o   = '0;
    count_o = '0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
    for (int i = 0; i < LIST_W; i++) begin
      count_o = count_o + CNT_W'(list_i[i]);
    end
    valid_o = |list_i;
  end

endmodule : reg_list_prienc
`default_nettype wire

// File: rtl/ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module      : ldm_stm_seq
// Description : Load/store-multiple sequencer. Walks a 16-bit register list
//               in ascending order and issues one word access per listed
//               register over a valid/ready memory handshake. Loads to R15
//               go out on the PC write port instead of the register file.
// Config      : LDMSTM_WRITEBACK_EN - when defined, a WB state writes the
//               updated base address back to base_reg after the transfers.
// Ports       : clk, rst_n            - clock, async active-low reset
//               start/is_load/up/reg_list/base_addr/base_reg - launch request
//               busy/done             - status (done is a one-cycle pulse)
//               mem_*                 - data memory handshake
//               rf_ra/rf_rd           - register file read (store path)
//               rf_we/rf_wa/rf_wd     - register file write (load / writeback)
//               pc_we/pc_wd           - R15 load
// Revision    : 1.0 - initial release
// ============================================================================
module ldm_stm_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_load,
  input  logic                 up,
  input  logic [LIST_W-1:0]    reg_list,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [REG_IDX_W-1:0] base_reg,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ready,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [REG_IDX_W-1:0] rf_ra,
  input  logic [DATA_W-1:0]    rf_rd,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_wa,
  output logic [DATA_W-1:0]    rf_wd,
  output logic                 pc_we,
  output logic [DATA_W-1:0]    pc_wd
);

  // State after the last transfer (or immediately, for an empty list).
`ifdef LDMSTM_WRITEBACK_EN
  localparam seq_state_e C_TAIL_STATE = ST_WB;
`else
  localparam seq_state_e C_TAIL_STATE = ST_DONE;
`endif

  seq_state_e          state_q, state_d;
  logic [LIST_W-1:0]   list_q,  list_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic                load_q,  load_d;

  logic [IDX_W-1:0]    w_cur_idx;
  logic                w_cur_vld;
  logic [CNT_W-1:0]    w_unused_cur_cnt;
  logic [IDX_W-1:0]    w_unused_start_idx;
  logic                w_start_vld;
  logic [CNT_W-1:0]    w_start_cnt;
  logic [ADDR_W-1:0]   w_start_off;
  logic [LIST_W-1:0]   w_list_cleared;
  logic                w_cur_is_pc;

  // Current register: lowest pending bit of the latched list.
  reg_list_prienc u_cur_enc (
    .list_i  (list_q),
    .idx_o   (w_cur_idx),
    .valid_o (w_cur_vld),
    .count_o (w_unused_cur_cnt)
  );

  // Launch-time decode of the incoming list: emptiness and word count.
  reg_list_prienc u_start_enc (
    .list_i  (reg_list),
    .idx_o   (w_unused_start_idx),
    .valid_o (w_start_vld),
    .count_o (w_start_cnt)
  );

  assign w_start_off    = ADDR_W'(w_start_cnt) * ADDR_W'(WORD_BYTES);
  assign w_list_cleared = list_q & ~(LIST_W'(1) << w_cur_idx);
  assign w_cur_is_pc    = (w_cur_idx == IDX_W'(PC_IDX));

`ifdef LDMSTM_WRITEBACK_EN
  logic [REG_IDX_W-1:0] wb_reg_q, wb_reg_d;
  logic [ADDR_W-1:0]    fin_q,    fin_d;
  logic                 wb_en_q,  wb_en_d;
  logic                 w_base_in_list;

  // A base register above R15 cannot appear in the list.
  assign w_base_in_list = ~base_reg[REG_IDX_W-1] & reg_list[base_reg[IDX_W-1:0]];
`else
  logic w_unused_base_reg;
  assign w_unused_base_reg = ^base_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      list_q   <= '0;
      addr_q   <= '0;
      load_q   <= 1'b0;
`ifdef LDMSTM_WRITEBACK_EN
      wb_reg_q <= '0;
      fin_q    <= '0;
      wb_en_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      list_q   <= list_d;
      addr_q   <= addr_d;
      load_q   <= load_d;
`ifdef LDMSTM_WRITEBACK_EN
      wb_reg_q <= wb_reg_d;
      fin_q    <= fin_d;
      wb_en_q  <= wb_en_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    addr_d    = addr_q;
    load_d    = load_q;
`ifdef LDMSTM_WRITEBACK_EN
    wb_reg_d  = wb_reg_q;
    fin_d     = fin_q;
    wb_en_d   = wb_en_q;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_ra     = '0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    pc_we     = 1'b0;
    pc_wd     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          list_d = reg_list;
          load_d = is_load;
          // Descending transfers still walk upward from the lowest address.
          addr_d = up ? base_addr : (base_addr - w_start_off);
`ifdef LDMSTM_WRITEBACK_EN
          wb_reg_d = base_reg;
          fin_d    = up ? (base_addr + w_start_off) : (base_addr - w_start_off);
          // A loaded base value takes priority; R15 is never written here.
          wb_en_d  = (base_reg != REG_IDX_W'(PC_IDX)) && !(is_load && w_base_in_list);
`endif
          state_d  = w_start_vld ? ST_XFER : C_TAIL_STATE;
        end
      end

      ST_XFER: begin
        busy     = 1'b1;
        mem_req  = w_cur_vld;
        mem_addr = addr_q;
        mem_we   = ~load_q;
        if (!load_q) begin
          rf_ra     = {1'b0, w_cur_idx};
          mem_wdata = rf_rd;
        end
        if (w_cur_vld && mem_ready) begin
          list_d = w_list_cleared;
          addr_d = addr_q + ADDR_W'(WORD_BYTES);
          // Load data is committed on the same edge as the handshake.
          if (load_q) begin
            if (w_cur_is_pc) begin
              pc_we = 1'b1;
              pc_wd = mem_rdata;
            end else begin
              rf_we = 1'b1;
              rf_wa = {1'b0, w_cur_idx};
              rf_wd = mem_rdata;
            end
          end
        end
        if (!w_cur_vld || (mem_ready && (w_list_cleared == '0))) begin
          state_d = C_TAIL_STATE;
        end
      end

`ifdef LDMSTM_WRITEBACK_EN
      ST_WB: begin
        busy  = 1'b1;
        rf_we = wb_en_q;
        if (wb_en_q) begin
          rf_wa = wb_reg_q;
          rf_wd = DATA_W'(fin_q);
        end
        state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule : ldm_stm_seq
`default_nettype wire

// File: tb/tb_ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldm_stm_seq
// Description : Scoreboard bench for ldm_stm_seq. The driver expands each
//               operation into its expected word accesses and completion
//               record; a monitor compares them with what the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_seq;

`ifdef LDMSTM_WRITEBACK_EN
  localparam int WB_CYC = 1;
`else
  localparam int WB_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, up = 1'b1;
  logic [15:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic [4:0]  base_reg = '0;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd, pc_wd;
  logic        rf_we, pc_we;

  always #5 clk = ~clk;

  ldm_stm_seq #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .up(up),
    .reg_list(reg_list), .base_addr(base_addr), .base_reg(base_reg),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  r;
  } xfer_t;

  typedef struct {
    int          n;
    bit          wb;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    int          start_cyc;
  } op_t;

  xfer_t xq[$];
  op_t   oq[$];
  logic [31:0] rf_model [16];
  logic [31:0] mem_model [logic [31:0]];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, stall_left = 0, ready_mode = 0;

  assign rf_rd = rf_model[rf_ra[3:0]];

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  always @(posedge clk) cyc++;

  // Memory side: ready pattern and read data for the presented address.
  always @(posedge clk) begin
    #1;
    if (mem_req && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 1) begin
      mem_ready = ($urandom_range(0, 3) != 0);
    end else begin
      mem_ready = 1'b1;
    end
    mem_rdata = mem_rd(mem_addr);
  end

  // Monitor
  int    waits = 0, xf = 0, wbs = 0;
  xfer_t e;
  op_t   o;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_pc_we", 32'(pc_we), 32'd0);
      waits = 0; xf = 0; wbs = 0;
    end else begin
      if (mem_req) begin
        chk("busy_xfer", 32'(busy), 32'd1);
        if (xq.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          e = xq[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
          if (mem_ready) begin
            if (!e.we && e.r != 4'd15) begin
              chk("ld_rf_we", 32'(rf_we), 32'd1);
              chk("ld_rf_wa", 32'(rf_wa), 32'(e.r));
              chk("ld_rf_wd", rf_wd, e.data);
              chk("ld_pc_we", 32'(pc_we), 32'd0);
            end else if (!e.we) begin
              chk("ld15_pc_we", 32'(pc_we), 32'd1);
              chk("ld15_pc_wd", pc_wd, e.data);
              chk("ld15_rf_we", 32'(rf_we), 32'd0);
            end else begin
              chk("st_rf_we", 32'(rf_we), 32'd0);
              chk("st_pc_we", 32'(pc_we), 32'd0);
            end
            void'(xq.pop_front());
            xf++;
          end else begin
            waits++;
            chk("wait_rf_we", 32'(rf_we), 32'd0);
            chk("wait_pc_we", 32'(pc_we), 32'd0);
          end
        end
      end else begin
        chk("idle_pc_we", 32'(pc_we), 32'd0);
        if (rf_we) begin
          if (oq.size() == 0 || !oq[0].wb) begin
            fail("spurious_rf_we");
          end else begin
            chk("wb_rf_wa", 32'(rf_wa), 32'(oq[0].wb_reg));
            chk("wb_rf_wd", rf_wd, oq[0].wb_val);
            wbs++;
          end
        end
      end
      if (done) begin
        if (oq.size() == 0) begin
          fail("unexpected_done");
        end else begin
          o = oq.pop_front();
          chk("done_latency", 32'(cyc - o.start_cyc), 32'(o.n + 1 + WB_CYC + waits));
          chk("xfer_count", 32'(xf), 32'(o.n));
          chk("wb_count", 32'(wbs), o.wb ? 32'd1 : 32'd0);
          chk("busy_done", 32'(busy), 32'd0);
          done_cnt++;
        end
        waits = 0; xf = 0; wbs = 0;
      end
    end
  end

  // Reference: ascending walk over set bits from the lowest address.
  task automatic run_op(bit ld, bit u, logic [15:0] lst, logic [31:0] base,
                        logic [4:0] breg, int stalls, bit poke);
    int n;
    int target;
    int t;
    logic [31:0] a;
    logic [31:0] fin;
    xfer_t x;
    op_t   p;
    n = 0;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    a   = u ? base : base - 32'(4 * n);
    fin = u ? base + 32'(4 * n) : base - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        x.addr = a;
        x.we   = !ld;
        x.r    = 4'(i);
        x.data = ld ? mem_rd(a) : rf_model[i];
        xq.push_back(x);
        a = a + 32'd4;
      end
    end
    p.n      = n;
    p.wb     = (WB_CYC == 1) && (breg != 5'd15) && !(ld && !breg[4] && lst[breg[3:0]]);
    p.wb_reg = breg;
    p.wb_val = fin;
    target   = done_cnt + 1;
    stall_left = stalls;
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; up = u; reg_list = lst; base_addr = base; base_reg = breg;
    p.start_cyc = cyc;
    oq.push_back(p);
    @(posedge clk); #1;
    start = 1'b0;
    if (poke && n >= 2) begin
      @(posedge clk); #1;
      start = 1'b1; is_load = $urandom_range(0, 1) != 0; reg_list = 16'($urandom);
      base_addr = $urandom; base_reg = 5'($urandom_range(0, 15));
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt < target && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < target) begin
      fail("done_timeout");
      xq.delete();
      oq.delete();
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_pc_we"}, 32'(pc_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rf_ra"}, 32'(rf_ra), 32'd0);
    chk({tag, "_rf_wa"}, 32'(rf_wa), 32'd0);
    chk({tag, "_rf_wd"}, rf_wd, 32'd0);
    chk({tag, "_pc_wd"}, pc_wd, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_model[i] = $urandom;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Store-multiple ascending.
    rf_model[0] = 32'hA0; rf_model[1] = 32'hA1; rf_model[3] = 32'hA3;
    run_op(1'b0, 1'b1, 16'h000B, 32'h0000_1000, 5'd4, 0, 1'b0);

    // Load-multiple descending, including R15.
    mem_model[32'h2004] = 32'h11; mem_model[32'h2008] = 32'h22; mem_model[32'h200C] = 32'h33;
    run_op(1'b1, 1'b0, 16'h8006, 32'h0000_2010, 5'd7, 0, 1'b0);

    // Single store, zero wait then three wait cycles.
    run_op(1'b0, 1'b1, 16'h0020, 32'h0000_3000, 5'd1, 0, 1'b0);
    run_op(1'b0, 1'b1, 16'h0020, 32'h0000_3000, 5'd1, 3, 1'b0);

    // Empty list, address wrap.
    run_op(1'b0, 1'b1, 16'h0000, 32'h0000_4000, 5'd2, 0, 1'b0);
    run_op(1'b0, 1'b1, 16'h0100, 32'hFFFF_FFFC, 5'd3, 0, 1'b0);
    run_op(1'b1, 1'b1, 16'h0600, 32'hFFFF_FFFC, 5'd3, 0, 1'b0);

    // Writeback with base R4: not in list, then loaded.
    run_op(1'b0, 1'b1, 16'h0003, 32'h0000_5000, 5'd4, 0, 1'b0);
    run_op(1'b1, 1'b1, 16'h0011, 32'h0000_6000, 5'd4, 0, 1'b0);
    run_op(1'b0, 1'b0, 16'h0006, 32'h0000_6000, 5'd15, 0, 1'b0);

    // Reset during the 2nd of 4 load transfers.
    begin
      xfer_t x;
      op_t   p;
      logic [31:0] a;
      a = 32'h0000_7000;
      for (int i = 0; i < 16; i++) begin
        if (16'h00F0 & (16'h1 << i)) begin
          x.addr = a; x.we = 1'b0; x.r = 4'(i); x.data = mem_rd(a);
          xq.push_back(x);
          a = a + 32'd4;
        end
      end
      p.n = 4; p.wb = 1'b0; p.wb_reg = 5'd0; p.wb_val = 32'd0;
      @(posedge clk); #1;
      start = 1'b1; is_load = 1'b1; up = 1'b1; reg_list = 16'h00F0;
      base_addr = 32'h0000_7000; base_reg = 5'd15;
      p.start_cyc = cyc;
      oq.push_back(p);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      repeat (3) @(posedge clk);
      xq.delete();
      oq.delete();
      #3 rst_n = 1'b1;
    end
    run_op(1'b1, 1'b1, 16'h00F0, 32'h0000_7000, 5'd15, 0, 1'b0);

    // Randomized operations with random stalls and ignored mid-op starts.
    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] lst;
      logic [31:0] base;
      for (int i = 0; i < 16; i++) rf_model[i] = $urandom;
      lst = 16'($urandom);
      if ($urandom_range(0, 3) == 0) lst = lst & 16'($urandom);
      if ($urandom_range(0, 9) == 0) lst = 16'h0000;
      base = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 4) == 0) base = 32'hFFFF_FFF0 + {28'd0, 2'($urandom), 2'b00};
      if ($urandom_range(0, 4) == 0) base = {28'd0, 2'($urandom), 2'b00};
      run_op($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, lst, base,
             5'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
             $urandom_range(0, 2) == 0);
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ldm_stm_seq
`default_nettype wire
